status_save_stack: RTL and testbench

- LIFO save/restore store for the processor status word (1 | carry | negative | zero).
- Pushes the live CCR value when an interrupt is taken, and pops it on return-from-interrupt.
- On a pop it drives the restore command pair that the status register consumes: update strobe, and carry-flag code 2'b10 = "load saved status".
- Supports nested interrupts up to DEPTH levels and reports overflow/underflow as sticky error flags.

---
 rtl/status_save_stack.sv | 143 ++++++++++++++
 tb/tb_status_save_stack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/status_save_stack.sv
// Purpose : LIFO save/restore stack for the processor status word (interrupt nesting).
// Latency : push stores on the next edge; a pop shows savedStatus plus the restore strobe the cycle after popReq.
// Backpr. : none. With stall=1 requests are ignored and state is frozen; a full push or empty pop sets a sticky error.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   currentStatus            live CCR value to save on pushReq
//   pushReq / popReq         interrupt taken / RTI executing
//   stall                    pipeline stall; requests are ignored and state is held
//   clearErr                 clears the sticky error flags; a new error on the same edge wins
//   savedStatus              restored status word for the status register
//   restoreUpdate            one-cycle update strobe to the status register
//   restoreCode              2'b10 ("load saved status") while restoreUpdate=1, else 2'b00
//   count, empty, full       occupancy
//   overflowErr              sticky: a push was attempted while full
//   underflowErr             sticky: a pop was attempted while empty
module status_save_stack #(
  parameter int                 DEPTH        = 4,
  parameter int                 FLAG_W       = 4,
  parameter logic [FLAG_W-1:0]  RESET_STATUS = 4'b1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FLAG_W-1:0]        currentStatus,
  input  logic                     pushReq,
  input  logic                     popReq,
  input  logic                     stall,
  input  logic                     clearErr,
  output logic [FLAG_W-1:0]        savedStatus,
  output logic                     restoreUpdate,
  output logic [1:0]               restoreCode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflowErr,
  output logic                     underflowErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RESTORE = 1'b1} state_t;

  state_t              state, stateNext;
  logic [FLAG_W-1:0]   mem [DEPTH];
  logic [CW-1:0]       countNext;
  logic [CW-1:0]       countMinus1;
  logic [AW-1:0]       topIdx;
  logic [AW-1:0]       pushIdx;
  logic [FLAG_W-1:0]   savedNext;
  logic                memWe;
  logic [AW-1:0]       memWaddr;
  logic                ovfSet, unfSet;
  logic                overflowNext, underflowNext;

  assign empty         = (count == '0);
  assign full          = (count == DEPTH_CNT);
  assign restoreUpdate = (state == RESTORE);
  assign restoreCode   = restoreUpdate ? 2'b10 : 2'b00;

  // Top-of-stack index; when count is 0 it wraps to an index that is never read.
  assign countMinus1 = count - ONE;
  assign topIdx      = countMinus1[AW-1:0];
  // Only used when not full, so count < DEPTH and fits in AW bits.
  assign pushIdx     = count[AW-1:0];

  always_comb begin
    stateNext     = IDLE;
    countNext     = count;
    savedNext     = savedStatus;
    memWe         = 1'b0;
    memWaddr      = pushIdx;
    ovfSet        = 1'b0;
    unfSet        = 1'b0;
    overflowNext  = overflowErr;
    underflowNext = underflowErr;

    if (!stall) begin
      if (pushReq && popReq) begin
        if (empty) begin
          // Push goes through; the pop has nothing to restore.
          memWe     = 1'b1;
          memWaddr  = '0;
          countNext = ONE;
          savedNext = RESET_STATUS;
          unfSet    = 1'b1;
        end else begin
          // Swap: hand out the old top and overwrite it in place.
          savedNext = mem[topIdx];
          memWe     = 1'b1;
          memWaddr  = topIdx;
          stateNext = RESTORE;
        end
      end else if (pushReq) begin
        if (full) begin
          ovfSet = 1'b1;
        end else begin
          memWe     = 1'b1;
          memWaddr  = pushIdx;
          countNext = count + ONE;
        end
      end else if (popReq) begin
        if (empty) begin
          savedNext = RESET_STATUS;
          unfSet    = 1'b1;
        end else begin
          savedNext = mem[topIdx];
          countNext = countMinus1;
          stateNext = RESTORE;
        end
      end

      overflowNext  = (overflowErr  & ~clearErr) | ovfSet;
      underflowNext = (underflowErr & ~clearErr) | unfSet;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      savedStatus  <= RESET_STATUS;
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      state        <= stateNext;
      count        <= countNext;
      savedStatus  <= savedNext;
      overflowErr  <= overflowNext;
      underflowErr <= underflowNext;
    end
  end

  // Storage has no reset; entries are only read below count.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[memWaddr] <= currentStatus;
    end
  end

endmodule

// File: tb/tb_status_save_stack.sv
module tb_status_save_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] currentStatus;
  logic       pushReq, popReq, stall, clearErr;
  logic [3:0] savedStatus;
  logic       restoreUpdate;
  logic [1:0] restoreCode;
  logic [2:0] count;
  logic       empty, full, overflowErr, underflowErr;

  int total = 0;
  int bad   = 0;

  status_save_stack #(.DEPTH(4), .FLAG_W(4), .RESET_STATUS(4'b1000)) dut (
    .clk(clk), .reset(reset), .currentStatus(currentStatus),
    .pushReq(pushReq), .popReq(popReq), .stall(stall), .clearErr(clearErr),
    .savedStatus(savedStatus), .restoreUpdate(restoreUpdate), .restoreCode(restoreCode),
    .count(count), .empty(empty), .full(full),
    .overflowErr(overflowErr), .underflowErr(underflowErr)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    reset = 1'b0; pushReq = 1'b0; popReq = 1'b0; stall = 1'b0; clearErr = 1'b0;
    currentStatus = 4'b0000;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    total++; if (savedStatus !== 4'b1000) begin bad++; $display("FAIL reset_saved: got %b want 1000", savedStatus); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL reset_ru: got %b want 0", restoreUpdate); end
    total++; if (restoreCode !== 2'b00) begin bad++; $display("FAIL reset_code: got %b want 00", restoreCode); end
    total++; if ({overflowErr, underflowErr} !== 2'b00) begin bad++; $display("FAIL reset_errs: got %b want 00", {overflowErr, underflowErr}); end
  endtask

  task automatic test_nested();
    idleInputs();
    pushReq = 1'b1; currentStatus = 4'b1001; step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL nest_push1_count: got %0d want 1", count); end
    currentStatus = 4'b1100; step();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL nest_push2_count: got %0d want 2", count); end
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL nest_push_ru: got %b want 0", restoreUpdate); end
    pushReq = 1'b0; popReq = 1'b1; step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL nest_pop1_count: got %0d want 1", count); end
    total++; if (savedStatus !== 4'b1100) begin bad++; $display("FAIL nest_pop1_saved: got %b want 1100", savedStatus); end
    total++; if (restoreUpdate !== 1'b1) begin bad++; $display("FAIL nest_pop1_ru: got %b want 1", restoreUpdate); end
    total++; if (restoreCode !== 2'b10) begin bad++; $display("FAIL nest_pop1_code: got %b want 10", restoreCode); end
    popReq = 1'b0; step();
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL nest_gap_ru: got %b want 0", restoreUpdate); end
    total++; if (restoreCode !== 2'b00) begin bad++; $display("FAIL nest_gap_code: got %b want 00", restoreCode); end
    popReq = 1'b1; step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL nest_pop2_count: got %0d want 0", count); end
    total++; if (savedStatus !== 4'b1001) begin bad++; $display("FAIL nest_pop2_saved: got %b want 1001", savedStatus); end
    total++; if (restoreCode !== 2'b10) begin bad++; $display("FAIL nest_pop2_code: got %b want 10", restoreCode); end
    popReq = 1'b0; step();
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL nest_end_ru: got %b want 0", restoreUpdate); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL nest_end_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    logic [3:0] vals [4];
    vals[0] = 4'b1000; vals[1] = 4'b1001; vals[2] = 4'b1010; vals[3] = 4'b1011;
    idleInputs();
    pushReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      currentStatus = vals[i];
      step();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full4: got %b want 1", full); end
    total++; if (overflowErr !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflowErr); end
    currentStatus = 4'b1111; step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
    total++; if (overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflowErr); end
    // Held popReq: four back-to-back distinct restores.
    pushReq = 1'b0; popReq = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      total++; if (savedStatus !== vals[i]) begin bad++; $display("FAIL ovf_pop%0d_saved: got %b want %b", i, savedStatus, vals[i]); end
      total++; if (restoreUpdate !== 1'b1) begin bad++; $display("FAIL ovf_pop%0d_ru: got %b want 1", i, restoreUpdate); end
      total++; if (count !== 3'(i)) begin bad++; $display("FAIL ovf_pop%0d_count: got %0d want %0d", i, count, i); end
    end
    total++; if (overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflowErr); end
    popReq = 1'b0; clearErr = 1'b1; step();
    total++; if (overflowErr !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflowErr); end
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL ovf_end_ru: got %b want 0", restoreUpdate); end
    clearErr = 1'b0;
  endtask

  task automatic test_underflow();
    idleInputs();
    pushReq = 1'b1; currentStatus = 4'b1101; step();
    pushReq = 1'b0; popReq = 1'b1; step();
    total++; if (savedStatus !== 4'b1101) begin bad++; $display("FAIL unf_pre_saved: got %b want 1101", savedStatus); end
    step();
    total++; if (underflowErr !== 1'b1) begin bad++; $display("FAIL unf_flag: got %b want 1", underflowErr); end
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL unf_ru: got %b want 0", restoreUpdate); end
    total++; if (savedStatus !== 4'b1000) begin bad++; $display("FAIL unf_saved: got %b want 1000", savedStatus); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL unf_count: got %0d want 0", count); end
    popReq = 1'b0; clearErr = 1'b1; step();
    total++; if (underflowErr !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", underflowErr); end
    popReq = 1'b1; step();
    total++; if (underflowErr !== 1'b1) begin bad++; $display("FAIL unf_set_wins: got %b want 1", underflowErr); end
    popReq = 1'b0; step();
    total++; if (underflowErr !== 1'b0) begin bad++; $display("FAIL unf_clear2: got %b want 0", underflowErr); end
    clearErr = 1'b0;
    // Push+pop on an empty stack: push done, pop flagged, no strobe.
    pushReq = 1'b1; popReq = 1'b1; currentStatus = 4'b1110; step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL pp_empty_count: got %0d want 1", count); end
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL pp_empty_ru: got %b want 0", restoreUpdate); end
    total++; if (underflowErr !== 1'b1) begin bad++; $display("FAIL pp_empty_unf: got %b want 1", underflowErr); end
    pushReq = 1'b0; clearErr = 1'b1; step();
    total++; if (savedStatus !== 4'b1110) begin bad++; $display("FAIL pp_empty_pop: got %b want 1110", savedStatus); end
    total++; if (underflowErr !== 1'b0) begin bad++; $display("FAIL pp_empty_clr: got %b want 0", underflowErr); end
    popReq = 1'b0; clearErr = 1'b0; step();
  endtask

  task automatic test_swap_stall();
    idleInputs();
    pushReq = 1'b1; currentStatus = 4'b1101; step();
    popReq = 1'b1; currentStatus = 4'b1010; step();
    total++; if (savedStatus !== 4'b1101) begin bad++; $display("FAIL swap_saved: got %b want 1101", savedStatus); end
    total++; if (restoreUpdate !== 1'b1) begin bad++; $display("FAIL swap_ru: got %b want 1", restoreUpdate); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL swap_count: got %0d want 1", count); end
    stall = 1'b1; currentStatus = 4'b1111; step();
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL stall_ru: got %b want 0", restoreUpdate); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL stall_count: got %0d want 1", count); end
    total++; if (savedStatus !== 4'b1101) begin bad++; $display("FAIL stall_saved: got %b want 1101", savedStatus); end
    stall = 1'b0; pushReq = 1'b0; step();
    total++; if (savedStatus !== 4'b1010) begin bad++; $display("FAIL swap_newtop: got %b want 1010", savedStatus); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL swap_final_count: got %0d want 0", count); end
    popReq = 1'b0; step();
  endtask

  task automatic test_reset_mid_restore();
    idleInputs();
    pushReq = 1'b1; currentStatus = 4'b0110; step();
    pushReq = 1'b0; popReq = 1'b1; step();
    total++; if (restoreUpdate !== 1'b1) begin bad++; $display("FAIL rmr_ru_pre: got %b want 1", restoreUpdate); end
    pushReq = 1'b1; currentStatus = 4'b0101; reset = 1'b1; step();
    total++; if (restoreUpdate !== 1'b0) begin bad++; $display("FAIL rmr_ru: got %b want 0", restoreUpdate); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rmr_count: got %0d want 0", count); end
    total++; if (savedStatus !== 4'b1000) begin bad++; $display("FAIL rmr_saved: got %b want 1000", savedStatus); end
    idleInputs(); step();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_nested();
    test_overflow();
    test_underflow();
    test_swap_stall();
    test_reset_mid_restore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
